// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C receive controller slice.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // Address byte selects us only as a write (R/W bit = 0) to our address.
    function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                        input logic [ADDR_W-1:0] dev_addr);
        return (addr_byte[BYTE_W-1:1] == dev_addr) && !addr_byte[0];
    endfunction

endpackage

// File: rtl/i2c_edge_detect.sv
// SCL edge strobes and START/STOP detection from already-synchronized SCL/SDA.
module i2c_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // Previous-cycle samples; reset to the idle-bus level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_in;
            sda_q <= sda_in;
        end
    end

    assign scl_rise  =  scl_in & ~scl_q;
    assign scl_fall  = ~scl_in &  scl_q;
    assign start_det =  scl_in &  sda_q & ~sda_in;
    assign stop_det  =  scl_in & ~sda_q &  sda_in;

endmodule

// File: rtl/i2c_rx_controller.sv
// I2C write-only target: address match, byte assembly, ACK/NACK drive on SDA.
module i2c_rx_controller
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h2A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    input  logic              rx_ready,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    output logic              addr_hit,
    output logic              busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BYTE_W-1:0]   shift;
    logic                ack_grant;
    logic                ack_phase;
    logic [BYTE_W-1:0]   shift_nxt_c;
    logic                last_bit_c;
    logic                start_ev_c;
    logic                stop_ev_c;

    // While we hold SDA low our own pull would look like bus conditions; ignore them.
    assign start_ev_c  = start_det & ~sda_oe;
    assign stop_ev_c   = stop_det  & ~sda_oe;
    assign shift_nxt_c = {shift[BYTE_W-2:0], sda_in};
    assign last_bit_c  = (bit_cnt == CNT_W'(BYTE_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            sda_oe     <= 1'b0;
            addr_hit   <= 1'b0;
            busy       <= 1'b0;
            ack_grant  <= 1'b0;
            ack_phase  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (stop_ev_c) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                shift     <= '0;
                sda_oe    <= 1'b0;
                addr_hit  <= 1'b0;
                busy      <= 1'b0;
                ack_grant <= 1'b0;
                ack_phase <= 1'b0;
            end else if (start_ev_c) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                shift     <= '0;
                sda_oe    <= 1'b0;
                addr_hit  <= 1'b0;
                busy      <= 1'b1;
                ack_grant <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                unique case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= shift_nxt_c;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_bit_c) begin
                                ack_phase <= 1'b0;
                                if (addr_match(shift_nxt_c, DEV_ADDR)) begin
                                    state     <= ADDR_ACK;
                                    addr_hit  <= 1'b1;
                                    ack_grant <= 1'b1;
                                end else begin
                                    state     <= IGNORE;
                                    ack_grant <= 1'b0;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift   <= shift_nxt_c;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_bit_c) begin
                                state     <= DATA_ACK;
                                ack_phase <= 1'b0;
                                ack_grant <= rx_ready;
                                if (rx_ready) begin
                                    byte_valid <= 1'b1;
                                    byte_data  <= shift_nxt_c;
                                end
                            end
                        end
                    end
                    // First SCL fall opens the ACK bit, second closes it.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= ack_grant;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= DATA;
                                bit_cnt   <= '0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_rx_controller.md
I2C_RX_CONTROLLER -- requirements
Module: i2c_rx_controller

Interface
REQ-001 Parameter DEV_ADDR, default 7'h2A, 7-bit target address this block answers to.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl_in  input  1  I2C SCL, already synchronized to clk.
REQ-005 sda_in  input  1  I2C SDA, already synchronized to clk.
REQ-006 rx_ready  input  1  downstream can accept a data byte; sampled for the ACK decision.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 byte_data  output  8  last received data byte, MSB first on the wire; held until the next byte_valid.
REQ-009 byte_valid  output  1  one-cycle strobe qualifying byte_data.
REQ-010 addr_hit  output  1  high while a write transaction addressed to DEV_ADDR is active.
REQ-011 busy  output  1  high from START detection to STOP detection, for any address.

Function
REQ-012 Edge detection: scl_rise/scl_fall are one-cycle strobes from registered scl_in; START = sda_in 1->0 while scl_in=1; STOP = sda_in 0->1 while scl_in=1.
REQ-013 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-014 IDLE->ADDR on START; bit counter cleared to 0, shift register cleared.
REQ-015 ADDR/DATA: on each scl_rise, shift sda_in into bit 0 (previous bits move toward MSB); 3-bit counter increments, wrapping 7->0.
REQ-016 8th scl_rise in ADDR: if shift[7:1]==DEV_ADDR and shift[0]==0 (write) -> ADDR_ACK, addr_hit=1; otherwise -> IGNORE, no ACK.
REQ-017 8th scl_rise in DATA: if rx_ready=1 in that cycle, byte_valid=1 the next cycle with byte_data = the 8 bits, -> DATA_ACK; if rx_ready=0, no byte_valid, byte dropped, -> DATA_ACK with ACK suppressed (NACK).
REQ-018 ACK states: on first scl_fall assert sda_oe (only if ACK granted); on next scl_fall deassert sda_oe, go to DATA, counter=0.
REQ-019 sda_oe never asserts outside ADDR_ACK/DATA_ACK.
REQ-020 IGNORE: sda_oe=0, no byte_valid; exits only on START or STOP.
REQ-021 STOP in any state -> IDLE next cycle: sda_oe=0, addr_hit=0, busy=0; partial byte discarded, no byte_valid.
REQ-022 Repeated START in any non-IDLE state -> ADDR, counter and shift register cleared, addr_hit=0, sda_oe=0.
REQ-023 START/STOP coinciding with scl_rise in the same cycle: START/STOP takes priority; no bit is shifted.
REQ-024 SDA transitions while scl_in=1 inside an ACK window are not treated as START/STOP when sda_oe=1.

Reset
REQ-025 Reset: state=IDLE, counter=0, shift=8'h00, byte_data=8'h00, byte_valid=0, sda_oe=0, addr_hit=0, busy=0, edge-detect registers=1 (bus idle).
REQ-026 Reset asserted mid-ACK releases sda_oe in the cycle after reset is sampled.

Structure
REQ-027 Package i2c_pkg holds the state enum, ADDR_W=7, and BYTE_W=8.
REQ-028 Sub-module i2c_edge_detect produces scl_rise, scl_fall, start_det, stop_det; the controller holds the FSM, counter, and shift register.

Verification
REQ-029 START, 0x54, ACK, 0xA5 with rx_ready=1, STOP -> sda_oe low in both ACK windows, one byte_valid with byte_data=0xA5, addr_hit 1->0 at STOP.
REQ-030 START, 0x56 (wrong address) -> no sda_oe, IGNORE, busy=1, addr_hit=0; STOP -> busy=0.
REQ-031 START, 0x55 (read to DEV_ADDR) -> NACK, IGNORE, no byte_valid.
REQ-032 Addressed write of 0x3C with rx_ready=0 -> no byte_valid, sda_oe stays 0 in the DATA_ACK window; next byte 0x11 with rx_ready=1 -> ACK and byte_valid with 0x11.
REQ-033 STOP after 4 data bits; then repeated START mid-byte followed by 0x54 -> no byte_valid from partial bytes; ACK for the new address.
REQ-034 Reset asserted while sda_oe=1 -> sda_oe=0 the next cycle, state IDLE, all outputs at reset values.
